// File: rtl/hist_eq_pkg.sv
// hist_eq_pkg: constants and types shared by the histogram equalizer stages.
// Holds the tag that marks a valid scratchpad entry, the default bin count,
// the count/cdf widths and the CDF sweep FSM state encoding.
package hist_eq_pkg;

  // Scratchpad entries carry this tag in bits [31:16] when they are valid.
  localparam logic [15:0] HIST_TAG = 16'hAAAA;

  localparam int NUM_BINS = 256;
  localparam int COUNT_W  = 16;
  localparam int CDF_W    = 17;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } hist_state_t;

  // A bin that was never written is untagged and contributes nothing.
  function automatic logic [COUNT_W-1:0] tagged_count(input logic [31:0] entry);
    return (entry[31:16] == HIST_TAG) ? entry[15:0] : '0;
  endfunction

endpackage

// File: rtl/hist_cdf_scale.sv
// hist_cdf_scale: maps a cumulative count to an 8-bit equalized level.
//   eq = (cdf * 255) >> pixel_count_log2, clamped to 0xFF.
// Ports:
//   cdf               in  17  cumulative count including the current bin
//   pixel_count_log2  in  5   log2 of the pixel count of the image
//   eq                out 8   equalized output level
module hist_cdf_scale (
  input  logic [16:0] cdf,
  input  logic [4:0]  pixel_count_log2,
  output logic [7:0]  eq
);

  logic [24:0] product;
  logic [24:0] shifted;

  always_comb begin
    // x*255 as (x<<8)-x; 17+8 bits cannot overflow 25 bits.
    product = {cdf, 8'b0} - {8'b0, cdf};
    shifted = product >> pixel_count_log2;
    // Oversized or corrupt histograms saturate instead of wrapping.
    eq      = (|shifted[24:8]) ? 8'hFF : shifted[7:0];
  end

endmodule

// File: rtl/hist_cdf_pipeline.sv
// hist_cdf_pipeline: sweeps every histogram bin of m2, accumulates the CDF and
// writes the equalization mapping table into m3.
// Optional feature: define HIST_CLEAR_EN to clear each m2 bin right after its
// data has been consumed, leaving m2 untagged for the next frame.
// Ports:
//   clock        in   1    system clock
//   rst_n        in   1    asynchronous active-low reset
//   start        in   1    begins a sweep when idle or done
//   m2ReadVal    in   128  m2 data for the previous cycle's m2ReadAddr
//   m2ReadAddr   out  16   bin being read
//   m2WriteAddr  out  16   bin being cleared (HIST_CLEAR_EN only)
//   m2WriteVal   out  128  always zero
//   m2WE         out  1    m2 clear strobe
//   m3WriteAddr  out  16   bin index of the mapping entry
//   m3WriteVal   out  128  {96'b0, tag, 8'h00, eq}
//   m3WE         out  1    m3 write strobe
//   done         out  1    sweep complete
module hist_cdf_pipeline #(
  parameter int NUM_BINS         = hist_eq_pkg::NUM_BINS,
  parameter int PIXEL_COUNT_LOG2 = 6
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] m2ReadVal,
  output logic [15:0]  m2ReadAddr,
  output logic [15:0]  m2WriteAddr,
  output logic [127:0] m2WriteVal,
  output logic         m2WE,
  output logic [15:0]  m3WriteAddr,
  output logic [127:0] m3WriteVal,
  output logic         m3WE,
  output logic         done
);
  import hist_eq_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);

  hist_state_t state_reg, state_next;

  logic [ADDR_W-1:0]  rd_addr_reg;
  logic               drain_cnt_reg;
  logic               rd_valid_reg;      // m2ReadVal holds data for rd_addr_d1_reg
  logic [ADDR_W-1:0]  rd_addr_d1_reg;
  logic [CDF_W-1:0]   cdf_reg;
  logic [CDF_W-1:0]   cdf_next;
  logic [COUNT_W-1:0] count;
  logic [7:0]         eq;
  logic               m3_we_reg;
  logic [ADDR_W-1:0]  m3_addr_reg;
  logic [DATA_W-1:0]  m3_val_reg;
  logic               issue;
  logic               sweep_start;
  logic               unused_read_bits;

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = READ;
      READ:  if (rd_addr_reg == LAST_ADDR) state_next = DRAIN;
      DRAIN: if (drain_cnt_reg) state_next = DONE;
      DONE:  if (start) state_next = READ;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    issue       = (state_reg == READ);
    done        = (state_reg == DONE);
    sweep_start = start && ((state_reg == IDLE) || (state_reg == DONE));
  end

  // Bin count of the entry returned this cycle and the CDF including it.
  assign count    = tagged_count(m2ReadVal[31:0]);
  assign cdf_next = cdf_reg + CDF_W'(count);
  assign unused_read_bits = ^m2ReadVal[127:32];

  hist_cdf_scale u_scale (
    .cdf              (cdf_next),
    .pixel_count_log2 (5'(PIXEL_COUNT_LOG2)),
    .eq               (eq)
  );

  // Address generation, CDF accumulation and m3 write pipeline.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_reg    <= '0;
      drain_cnt_reg  <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_addr_d1_reg <= '0;
      cdf_reg        <= '0;
      m3_we_reg      <= 1'b0;
      m3_addr_reg    <= '0;
      m3_val_reg     <= '0;
    end else begin
      if (sweep_start)
        rd_addr_reg <= '0;
      else if (issue)
        rd_addr_reg <= (rd_addr_reg == LAST_ADDR) ? '0 : rd_addr_reg + 1'b1;

      drain_cnt_reg  <= (state_reg == DRAIN) ? ~drain_cnt_reg : 1'b0;
      rd_valid_reg   <= issue;
      rd_addr_d1_reg <= rd_addr_reg;

      if (sweep_start)
        cdf_reg <= '0;
      else if (rd_valid_reg)
        cdf_reg <= cdf_next;

      m3_we_reg <= rd_valid_reg;
      if (rd_valid_reg) begin
        m3_addr_reg <= rd_addr_d1_reg;
        m3_val_reg  <= {96'b0, HIST_TAG, 8'h00, eq};
      end
    end
  end

  assign m2ReadAddr  = rd_addr_reg;
  assign m3WE        = m3_we_reg;
  assign m3WriteAddr = m3_addr_reg;
  assign m3WriteVal  = m3_val_reg;

`ifdef HIST_CLEAR_EN
  // Clear bin i while its data is being consumed; m2 is dual-port so this
  // runs alongside the read of bin i+1.
  assign m2WE        = rd_valid_reg;
  assign m2WriteAddr = rd_valid_reg ? rd_addr_d1_reg : '0;
  assign m2WriteVal  = '0;
`else
  assign m2WE        = 1'b0;
  assign m2WriteAddr = '0;
  assign m2WriteVal  = '0;
`endif

endmodule

// File: doc/hist_cdf_pipeline.md
# hist_cdf_pipeline

Second stage of the histogram equalizer. Once the input pipeline has finished counting pixel values into scratchpad memory m2, this block sweeps all 256 histogram bins in order and accumulates the cumulative distribution. It scales each CDF value to an 8-bit equalized output level and writes the resulting 256-entry mapping table into scratchpad m3. The output stage later uses m3 to remap m1 into m4.

## Interface
Parameters:
- NUM_BINS, 256: histogram bins; also the number of m2 reads and m3 writes.
- PIXEL_COUNT_LOG2, 6: log2 of total pixels in the image (64 by default); used as the scaling shift.

Ports:
- clock  in  1  system clock; all state is updated on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- start  in  1  level/pulse; sampled in IDLE or DONE to begin a sweep.
- m2ReadVal  in  128  m2 read data for the previous cycle's m2ReadAddr; bits [31:16] are the tag, bits [15:0] are the count.
- m2ReadAddr  out  16  bin index being read.
- m2WriteAddr  out  16  bin being cleared (HIST_CLEAR_EN only).
- m2WriteVal  out  128  always 0.
- m2WE  out  1  m2 clear strobe.
- m3WriteAddr  out  16  bin index of the mapping entry.
- m3WriteVal  out  128  {96'b0, 16'hAAAA, 8'h00, eq[7:0]}.
- m3WE  out  1  m3 write strobe.
- done  out  1  sweep complete.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE -> READ on start. READ issues m2ReadAddr = 0..NUM_BINS-1, one address per cycle.
- READ -> DRAIN after address NUM_BINS-1 is issued. DRAIN lasts 2 cycles to flush the pipeline, then goes to DONE.
- DONE holds done=1. On start it clears done and returns to READ with address 0; the CDF is cleared.
- start is ignored while in READ or DRAIN.
- Tag rule: a bin count is m2ReadVal[15:0] only if m2ReadVal[31:16]==16'hAAAA. Otherwise the count is 0, because an untagged entry is a never-written bin.
- cdf is a 17-bit accumulator: cdf += count. It is cleared on entry to READ.
- eq = (cdf_after_add * 255) >> PIXEL_COUNT_LOG2, computed with a 25-bit product.
- eq is clamped to 8'hFF if the shifted result exceeds 255. This happens for corrupt or oversized histograms.
- Entry layout: m3WriteAddr = bin index. m3WriteVal carries the 16'hAAAA tag so the output stage can validate the entry.
- Exactly NUM_BINS m3 writes occur per sweep, in ascending bin order.

## Timing
- Reset values:
  - FSM = IDLE, cdf = 0.
  - All addresses 0, all write values 0.
  - m2WE = 0, m3WE = 0, done = 0.
- Reset mid-sweep aborts immediately. No further writes occur, and no partial done is produced.
- m2 read latency is 1 cycle: data for the address issued in cycle t is valid in t+1.
- Cycle t: m2ReadAddr = i.
- Cycle t+1: count(i) is added into the registered cdf.
- Cycle t+2: m3WE = 1, m3WriteAddr = i, m3WriteVal = eq(i).
- Address-to-m3-write latency is 2 cycles.
- With start sampled at cycle 0:
  - The first m2ReadAddr is at cycle 1.
  - The last m3 write is at cycle NUM_BINS+2.
  - done rises at cycle NUM_BINS+3.
- m3WE is a one-cycle strobe per bin and is never asserted outside a sweep.

## Configuration
- HIST_CLEAR_EN defined:
  - In the cycle bin i's data is consumed (t+1), drive m2WE = 1, m2WriteAddr = i, m2WriteVal = 0.
  - This leaves m2 untagged, ready for the next frame.
  - m2 is dual-port; the read of i+1 and the clear of i happen in the same cycle.
- HIST_CLEAR_EN undefined: m2WE, m2WriteAddr and m2WriteVal are held at 0, and m2 is left unchanged.

## Structure
- Package hist_eq_pkg holds:
  - the tag constant HIST_TAG = 16'hAAAA;
  - NUM_BINS;
  - the count width (16) and the cdf width (17);
  - the FSM state enum.
  The input pipeline will import the same package.
- Sub-module hist_cdf_scale: a combinational block for multiply by 255, shift and clamp, with inputs cdf and PIXEL_COUNT_LOG2 and output eq[7:0]. It is instantiated once.

## Test plan
- All 64 pixels = 0x10 (bin 16 tagged with count 64, all other bins untagged):
  - m3 entries 0-15 hold eq 0x00.
  - m3 entries 16-255 hold eq 0xFF.
  - done at cycle 259.
- Bins 0-63 each tagged with count 1: bin k gives eq = ((k+1)*255)>>6. Check bin 0 = 0x03, bin 31 = 0x7F, bin 63 = 0xFF.
- m2 all zero (every bin untagged): all 256 writes carry eq 0x00 with the tag 16'hAAAA present; done asserts.
- Bin 0 tagged with count 0xFFFF: clamp applies and every entry holds 0xFF.
- rst_n asserted at cycle 100 of a sweep: m3WE falls immediately, done = 0, FSM is IDLE. A following start produces a full clean sweep.
- HIST_CLEAR_EN defined: 256 m2 clears occur, each one cycle after the matching read address. A second sweep then produces all eq 0x00.
